// File: rtl/lockpick_vault.sv
// lockpick_vault: two-stream key XOR, iterative Feistel/S-box hash, compare
// against a programmable target, and ready/valid result streaming with lockout.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     begin a game (IDLE only)
//   in_valid, in_data[7:0]    key byte stream (INPUT_A then INPUT_B)
//   tgt_we, tgt_data[7:0]     target byte write (IDLE only, auto-increment)
//   out_ready                 result sink ready
//   out_valid, out_data[7:0]  registered result byte stream
//   status[1:0]               00 none, 01 error, 10 win, 11 locked out
//   attempts_left[2:0]        remaining failed compares this game
//   busy                      high in any state except IDLE
module lockpick_vault #(
    parameter int unsigned  KEY_BYTES      = 32,
    parameter int unsigned  ROUNDS         = 3,
    parameter int unsigned  MAX_ATTEMPTS   = 3,
    parameter int unsigned  LOCKOUT_CYCLES = 16,
    parameter logic [255:0] DEFAULT_TARGET =
        256'hCAFEBABE_12345678_DEADBEEF_FEEDFACE_C001D00D_BADC0DE5_BAADF00D_0BADBEEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       tgt_we,
    input  logic [7:0] tgt_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [1:0] status,
    output logic [2:0] attempts_left,
    output logic       busy
);
    localparam int unsigned KW = KEY_BYTES * 8;
    localparam int unsigned L  = KEY_BYTES * 2;
    localparam int unsigned H  = L / 2;
    localparam int unsigned Q  = L / 4;
    localparam int unsigned CW = $clog2(KEY_BYTES);
    localparam int unsigned RW = 4;
    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [CW-1:0] LAST_BYTE  = CW'(KEY_BYTES - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
    localparam logic [LW-1:0] LAST_LOCK  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]    ATT_INIT   = 3'(MAX_ATTEMPTS);

    localparam logic [1:0]  ST_NONE = 2'b00;
    localparam logic [1:0]  ST_ERR  = 2'b01;
    localparam logic [1:0]  ST_WIN  = 2'b10;
    localparam logic [1:0]  ST_LOCK = 2'b11;
    localparam logic [31:0] MSG_WIN  = 32'hFACEFACE;
    localparam logic [31:0] MSG_LOCK = 32'hDEADDEAD;
    localparam logic [31:0] MSG_ERR  = 32'hBAD0BAD0;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [2:0] {
        S_IDLE, S_INPUT_A, S_INPUT_B, S_HASH, S_COMPARE, S_OUTPUT, S_LOCKED
    } state_t;

    state_t        state, next_state;
    logic [KW-1:0] key_a, key_b, target;
    logic [CW-1:0] cnt, tgt_idx;
    logic [RW-1:0] rnd_cnt;
    logic [LW-1:0] lock_cnt;
    logic [L-1:0]  ha, hb, hc, hd;
    logic [31:0]   msg;

    logic [KW-1:0] key_b_m, x_pre;
    logic [L-1:0]  f0, f1, f2, f3, na, nb, nc, nd, ra;
    logic          match, last_in, fire;
    logic [1:0]    status_c, nxt_sel;
    logic [31:0]   msg_c;

    // Preload source: key_b with the byte being accepted this cycle merged in
    always_comb begin
        key_b_m = key_b;
        key_b_m[{cnt, 3'b000} +: 8] = in_data;
        x_pre = key_a ^ key_b_m;
    end

    // One hash round over the A/B/C/D lanes
    always_comb begin
        f1 = '0;
        f3 = '0;
        f0 = ((hb ^ hd) + (ha | hc)) ^ {hc[H-1:0], hd[H-1:0]};
        for (int j = 0; j < int'(L / 8); j++) begin
            f1[8*j +: 8] = {f0[8*j +: 7], f0[8*j+7]};
        end
        f2 = (f1 << 13) | (f1 >> (L - 13));
        for (int j = 0; j < int'(L / 8); j++) begin
            f3[8*j +: 8] = SBOX[f2[8*j +: 8]];
        end
        na = ha ^ f3;
        nb = (hb << (H + 1)) | (hb >> (H - 1));
        nc = hc + na;
        nd = ~hd ^ nb;
        ra = (na << Q) | (na >> (L - Q));
    end

    // Compare outcome and stream helpers
    always_comb begin
        match    = ({ha, hb, hc, hd} == target);
        status_c = ST_ERR;
        msg_c    = MSG_ERR;
        if (match) begin
            status_c = ST_WIN;
            msg_c    = MSG_WIN;
        end else if (attempts_left == 3'd1) begin
            status_c = ST_LOCK;
            msg_c    = MSG_LOCK;
        end
        last_in = in_valid && (cnt == LAST_BYTE);
        fire    = out_valid && out_ready;
        nxt_sel = cnt[1:0] + 2'd1;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_INPUT_A;
            S_INPUT_A: if (last_in) next_state = S_INPUT_B;
            S_INPUT_B: if (last_in) next_state = S_HASH;
            S_HASH:    if (rnd_cnt == LAST_ROUND) next_state = S_COMPARE;
            S_COMPARE: next_state = S_OUTPUT;
            S_OUTPUT: begin
                if (fire && (cnt == LAST_BYTE)) begin
                    if (status == ST_WIN)       next_state = S_IDLE;
                    else if (status == ST_LOCK) next_state = S_LOCKED;
                    else                        next_state = S_INPUT_A;
                end
            end
            S_LOCKED:  if (lock_cnt == LAST_LOCK) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_a         <= '0;
            key_b         <= '0;
            target        <= KW'(DEFAULT_TARGET);
            cnt           <= '0;
            tgt_idx       <= '0;
            rnd_cnt       <= '0;
            lock_cnt      <= '0;
            ha            <= '0;
            hb            <= '0;
            hc            <= '0;
            hd            <= '0;
            msg           <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            status        <= ST_NONE;
            attempts_left <= ATT_INIT;
            busy          <= 1'b0;
        end else begin
            busy <= (next_state != S_IDLE);
            case (state)
                S_IDLE: begin
                    // start has priority; a coincident target write is dropped
                    if (start) begin
                        status        <= ST_NONE;
                        cnt           <= '0;
                        tgt_idx       <= '0;
                        attempts_left <= ATT_INIT;
                    end else if (tgt_we) begin
                        target[{tgt_idx, 3'b000} +: 8] <= tgt_data;
                        tgt_idx <= (tgt_idx == LAST_BYTE) ? '0 : tgt_idx + 1'b1;
                    end
                end
                S_INPUT_A: begin
                    if (in_valid) begin
                        key_a[{cnt, 3'b000} +: 8] <= in_data;
                        cnt <= last_in ? '0 : cnt + 1'b1;
                    end
                end
                S_INPUT_B: begin
                    if (in_valid) begin
                        key_b[{cnt, 3'b000} +: 8] <= in_data;
                        cnt <= last_in ? '0 : cnt + 1'b1;
                    end
                    if (last_in) begin
                        ha      <= x_pre[3*L +: L];
                        hb      <= x_pre[2*L +: L];
                        hc      <= x_pre[L +: L];
                        hd      <= x_pre[0 +: L];
                        rnd_cnt <= '0;
                    end
                end
                S_HASH: begin
                    ha      <= ra;
                    hb      <= nb;
                    hc      <= nc;
                    hd      <= nd;
                    rnd_cnt <= rnd_cnt + 1'b1;
                end
                S_COMPARE: begin
                    status    <= status_c;
                    msg       <= msg_c;
                    out_valid <= 1'b1;
                    out_data  <= msg_c[7:0];
                    cnt       <= '0;
                    if (!match) attempts_left <= attempts_left - 3'd1;
                end
                S_OUTPUT: begin
                    if (fire) begin
                        if (cnt == LAST_BYTE) begin
                            out_valid <= 1'b0;
                            cnt       <= '0;
                            lock_cnt  <= '0;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            out_data <= msg[{nxt_sel, 3'b000} +: 8];
                        end
                    end
                end
                S_LOCKED: begin
                    lock_cnt <= lock_cnt + 1'b1;
                    if (lock_cnt == LAST_LOCK) attempts_left <= ATT_INIT;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lockpick_vault.sv
// Self-checking bench for lockpick_vault: three instances (32/3, 8/1, 64/15)
// share data inputs; each has its own start and tgt_we strobes.
`timescale 1ns/1ps
module tb_lockpick_vault;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       start_v, tgt_we_v, ov, bz;
    logic             in_valid, out_ready;
    logic [7:0]       in_data, tgt_data;
    logic [2:0][7:0]  od;
    logic [2:0][1:0]  st;
    logic [2:0][2:0]  al;
    longint           cyc = 0;
    int               checks = 0;
    int               errors = 0;
    logic [7:0]       sbox_m [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lockpick_vault #(.KEY_BYTES(32), .ROUNDS(3)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_data(in_data),
        .tgt_we(tgt_we_v[0]), .tgt_data(tgt_data), .out_ready(out_ready), .out_valid(ov[0]),
        .out_data(od[0]), .status(st[0]), .attempts_left(al[0]), .busy(bz[0]));
    lockpick_vault #(.KEY_BYTES(8), .ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_data(in_data),
        .tgt_we(tgt_we_v[1]), .tgt_data(tgt_data), .out_ready(out_ready), .out_valid(ov[1]),
        .out_data(od[1]), .status(st[1]), .attempts_left(al[1]), .busy(bz[1]));
    lockpick_vault #(.KEY_BYTES(64), .ROUNDS(15)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_data(in_data),
        .tgt_we(tgt_we_v[2]), .tgt_data(tgt_data), .out_ready(out_ready), .out_valid(ov[2]),
        .out_data(od[2]), .status(st[2]), .attempts_left(al[2]), .busy(bz[2]));

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // GF(2^8) multiply, AES polynomial
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = '0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl8(logic [7:0] v, int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box derived from the field inverse plus affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] rotl_n(logic [127:0] v, int n, int l);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < l; i++) r[(i + n) % l] = v[i];
        return r;
    endfunction

    // Reference digest for key size kb and round count rounds
    function automatic logic [511:0] model(logic [511:0] x, int kb, int rounds);
        int l, h, q;
        logic [127:0] m, hm, a, b, c, d, f, g;
        logic [511:0] dg;
        l = kb * 2; h = kb; q = kb / 2;
        m  = (128'd1 << l) - 128'd1;
        hm = (128'd1 << h) - 128'd1;
        a = '0; b = '0; c = '0; d = '0; dg = '0;
        for (int i = 0; i < l; i++) begin
            d[i] = x[i]; c[i] = x[l+i]; b[i] = x[2*l+i]; a[i] = x[3*l+i];
        end
        for (int r = 0; r < rounds; r++) begin
            f = (((b ^ d) + (a | c)) & m) ^ (((c & hm) << h) | (d & hm));
            g = '0;
            for (int j = 0; j < l / 8; j++) g[8*j +: 8] = {f[8*j +: 7], f[8*j+7]};
            f = rotl_n(g, 13, l);
            g = '0;
            for (int j = 0; j < l / 8; j++) g[8*j +: 8] = sbox_m[f[8*j +: 8]];
            a = a ^ g;
            b = rotl_n(b, h + 1, l);
            c = (c + a) & m;
            d = (~d & m) ^ b;
            a = rotl_n(a, q, l);
        end
        for (int i = 0; i < l; i++) begin
            dg[i] = d[i]; dg[l+i] = c[i]; dg[2*l+i] = b[i]; dg[3*l+i] = a[i];
        end
        return dg;
    endfunction

    task automatic drive_target(int inst, int kb, logic [511:0] t);
        for (int i = 0; i < kb; i++) begin
            tgt_we_v[inst] = 1'b1;
            tgt_data = t[8*i +: 8];
            @(negedge clk);
        end
        tgt_we_v[inst] = 1'b0;
    endtask

    task automatic start_game(int inst);
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b0;
    endtask

    task automatic feed(int kb, logic [511:0] ka, logic [511:0] kbv, output longint c_last);
        c_last = 0;
        for (int i = 0; i < kb; i++) begin
            in_valid = 1'b1; in_data = ka[8*i +: 8];
            @(negedge clk);
        end
        for (int i = 0; i < kb; i++) begin
            in_valid = 1'b1; in_data = kbv[8*i +: 8];
            if (i == kb - 1) c_last = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Wait for the result, check latency/status, then drain kb bytes
    task automatic collect(int inst, int kb, int rounds, longint c_last, logic [31:0] pat,
                           bit rnd, logic [1:0] exp_st, logic [2:0] exp_al);
        int n, k, guard;
        bit stalled, r;
        logic [7:0] held;
        n = 0;
        while (!ov[inst] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(cyc - c_last), 64'(rounds + 2));
        check("status", 64'(st[inst]), 64'(exp_st));
        check("attempts", 64'(al[inst]), 64'(exp_al));
        k = 0; guard = 0; stalled = 1'b0; held = '0;
        while (k < kb && guard < 4000) begin
            check("ov_hi", 64'(ov[inst]), 64'd1);
            if (!ov[inst]) break;
            if (stalled) check("hold", 64'(od[inst]), 64'(held));
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            if (r) begin
                check("byte", 64'(od[inst]), 64'(pat[8*(k%4) +: 8]));
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = od[inst];
            end
            @(negedge clk);
            guard++;
        end
        check("xfers", 64'(k), 64'(kb));
        check("ov_fall", 64'(ov[inst]), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [511:0] ka, kbv, t, t0;
        longint cl;
        start_v = '0; tgt_we_v = '0; in_valid = 1'b0; in_data = '0;
        tgt_data = '0; out_ready = 1'b0;
        build_sbox();
        repeat (3) @(negedge clk);
        check("rst_ov", 64'(ov[0]), 64'd0);
        check("rst_od", 64'(od[0]), 64'd0);
        check("rst_status", 64'(st[0]), 64'd0);
        check("rst_attempts", 64'(al[0]), 64'd3);
        check("rst_busy", 64'(bz[0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Smallest key, single round
        ka = 512'h0123456789ABCDEF; kbv = 512'h0F1E2D3C4B5A6978;
        t = model(ka ^ kbv, 8, 1);
        drive_target(1, 8, t);
        start_game(1);
        feed(8, ka, kbv, cl);
        collect(1, 8, 1, cl, 32'hFACEFACE, 1'b0, 2'b10, 3'd3);
        check("win1_busy", 64'(bz[1]), 64'd0);

        // Largest key, max rounds, with backpressure
        ka = {8{64'h9E3779B97F4A7C15}}; kbv = {8{64'h243F6A8885A308D3}};
        ka[511:448] = 64'h1122334455667788;
        t = model(ka ^ kbv, 64, 15);
        drive_target(2, 64, t);
        start_game(2);
        feed(64, ka, kbv, cl);
        collect(2, 64, 15, cl, 32'hFACEFACE, 1'b1, 2'b10, 3'd3);
        check("win2_busy", 64'(bz[2]), 64'd0);

        // Win on the main instance with target = H(0)
        t0 = model('0, 32, 3);
        drive_target(0, 32, t0);
        start_game(0);
        feed(32, {64{8'hA5}}, {64{8'hA5}}, cl);
        collect(0, 32, 3, cl, 32'hFACEFACE, 1'b0, 2'b10, 3'd3);
        check("win0_busy", 64'(bz[0]), 64'd0);

        // start + tgt_we together, then tgt_we during HASH: target must survive
        tgt_we_v[0] = 1'b1; tgt_data = ~t0[7:0]; start_v[0] = 1'b1;
        @(negedge clk);
        tgt_we_v[0] = 1'b0; start_v[0] = 1'b0;
        feed(32, {64{8'hA5}}, {64{8'hA5}}, cl);
        tgt_we_v[0] = 1'b1; tgt_data = ~t0[7:0];
        @(negedge clk);
        tgt_we_v[0] = 1'b0;
        collect(0, 32, 3, cl, 32'hFACEFACE, 1'b0, 2'b10, 3'd3);

        // Reset in the middle of INPUT_B
        start_game(0);
        for (int i = 0; i < 42; i++) begin
            in_valid = 1'b1; in_data = 8'h5A;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("mid_busy", 64'(bz[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("arst_ov", 64'(ov[0]), 64'd0);
        check("arst_status", 64'(st[0]), 64'd0);
        check("arst_busy", 64'(bz[0]), 64'd0);
        check("arst_attempts", 64'(al[0]), 64'd3);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Target is back to default: X=0 game now fails
        start_game(0);
        feed(32, {64{8'hA5}}, {64{8'hA5}}, cl);
        collect(0, 32, 3, cl, 32'hBAD0BAD0, 1'b0, 2'b01, 3'd2);
        check("retry_busy", 64'(bz[0]), 64'd1);
        feed(32, '0, {64{8'h01}}, cl);
        collect(0, 32, 3, cl, 32'hBAD0BAD0, 1'b1, 2'b01, 3'd1);
        feed(32, '0, {64{8'h01}}, cl);
        collect(0, 32, 3, cl, 32'hDEADDEAD, 1'b0, 2'b11, 3'd0);

        // LOCKED for 16 cycles, start ignored
        for (int i = 0; i < 16; i++) begin
            check("lock_busy", 64'(bz[0]), 64'd1);
            check("lock_status", 64'(st[0]), 64'd3);
            start_v[0] = (i == 3);
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        check("unlock_busy", 64'(bz[0]), 64'd0);
        check("unlock_attempts", 64'(al[0]), 64'd3);
        check("unlock_status", 64'(st[0]), 64'd3);
        start_game(0);
        check("restart_status", 64'(st[0]), 64'd0);
        check("restart_busy", 64'(bz[0]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lockpick_vault.md
# lockpick_vault

Parametrised next-generation lockpick challenge engine. It accepts two key streams, XORs them and runs an iterative Feistel/S-box hash, one round per cycle. The digest is compared against a run-time programmable target, and a result message is streamed out under ready/valid backpressure. Repeated failures trigger a timed lockout. It sits behind the byte-wide host port, alongside the existing fixed-width game.

## Interface
- KEY_BYTES, 32, key/digest size in bytes; multiple of 4, range 8..64; lane width L = KEY_BYTES*2 bits
- ROUNDS, 3, hash rounds, range 1..15
- MAX_ATTEMPTS, 3, failed compares allowed before lockout, range 1..7
- LOCKOUT_CYCLES, 16, cycles spent in LOCKED, ≥1
- DEFAULT_TARGET, 256'hCAFEBABE_12345678_DEADBEEF_FEEDFACE_C001D00D_BADC0DE5_BAADF00D_0BADBEEF, reset target; low KEY_BYTES*8 bits used
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a game (IDLE only)
- in_valid  in  1  key byte strobe (INPUT_A/INPUT_B; always accepted)
- in_data  in  8  key byte
- tgt_we  in  1  target byte write (IDLE only)
- tgt_data  in  8  target byte
- out_ready  in  1  sink ready
- out_valid  out  1  result byte valid
- out_data  out  8  result byte
- status  out  2  00 none, 01 error, 10 win, 11 locked out
- attempts_left  out  3  MAX_ATTEMPTS minus failures this game
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, INPUT_A, INPUT_B, HASH, COMPARE, OUTPUT, LOCKED.
- IDLE:
  - start → INPUT_A; clears status to 00, resets the byte counter, sets attempts_left = MAX_ATTEMPTS.
  - tgt_we writes target byte at tgt_idx; tgt_idx wraps mod KEY_BYTES and resets on start.
  - start and tgt_we in the same cycle: start wins, write dropped. tgt_we outside IDLE is ignored.
- INPUT_A/INPUT_B: byte i of the stream goes to bits [8i+7:8i]. The accepted last byte (i = KEY_BYTES-1) advances INPUT_A→INPUT_B→HASH.
- HASH:
  - Preload with X = key_a ^ key_b; A = X[top L bits], then B, C, D descending.
  - Run ROUNDS cycles, one round per cycle. All arithmetic is mod 2^L.
  - F = ((B^D)+(A|C)) ^ {C[L/2-1:0], D[L/2-1:0]}.
  - Rotate each byte of F left by 1, then rotate F left by 13 mod L.
  - Substitute each byte of F with the AES S-box.
  - A ^= F; B = rotl(B, L/2+1); C += A (new A); D = ~D ^ B (new B); A = rotl(A, L/4).
  - Digest = {A,B,C,D}.
- COMPARE (1 cycle):
  - match = (digest == target).
  - On mismatch, attempts_left decrements.
  - status and msg are registered:
    - match: 10, FACEFACE
    - mismatch with attempts_left == 1 before the decrement: 11, DEADDEAD
    - otherwise: 01, BAD0BAD0
- OUTPUT:
  - Streams KEY_BYTES bytes; byte k = byte (k mod 4) of the 32-bit pattern, LSB first (FACEFACE → CE,FA,CE,FA…).
  - Byte count advances only on out_valid && out_ready.
  - After the last transfer: win → IDLE; lockout → LOCKED; else → INPUT_A with the counter cleared.
- LOCKED:
  - Counts LOCKOUT_CYCLES cycles, then → IDLE.
  - start is ignored; status holds 11.
  - attempts_left reloads on exit.
- The target persists across games; only rst restores DEFAULT_TARGET.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, status 00, attempts_left MAX_ATTEMPTS, busy 0, target DEFAULT_TARGET, counters 0.
- Reset mid-operation aborts immediately; no partial output continues.
- start at cycle t → INPUT_A at t+1; the first key byte can be accepted at t+1.
- Last B byte at cycle t → HASH during t+1..t+ROUNDS, COMPARE at t+ROUNDS+1, out_valid first high at t+ROUNDS+2.
- out_valid and out_data are registered. While out_valid && !out_ready, out_data holds stable.
- out_valid falls the cycle after the final transfer.
- Best-case game latency is 2*KEY_BYTES + ROUNDS + 2 + KEY_BYTES cycles.
- status updates the cycle after COMPARE and holds until the next accepted start or rst.
- in_valid and start in any other state are ignored.

## Test plan
- Reset defaults: assert rst mid-INPUT_B → out_valid 0, status 00, busy 0, target back to DEFAULT_TARGET (verified by a subsequent game against the model).
- Win with programmed target:
  - Write target = model H(0) via 32 tgt_we bytes.
  - Start; key_a = key_b = 0xA5 bytes → status 10, 32 bytes CE,FA,CE,FA…, → IDLE.
- Lockout with MAX_ATTEMPTS=3 and default target:
  - Run three games with key_a = 0x00.., key_b = 0x01.. → status 01 (attempts_left 2), then 01 (1), then 11 (0); bytes AD,DE,AD,DE.
  - LOCKED lasts 16 cycles; start during LOCKED is ignored.
- Backpressure: toggle out_ready 1/0 pseudo-randomly → exactly KEY_BYTES transfers, data stable while stalled, no byte skipped.
- Parameter sweep over KEY_BYTES ∈ {8,32,64} and ROUNDS ∈ {1,3,15} → digest matches model; out_valid first high exactly ROUNDS+2 cycles after the last key byte.
- Collisions: start and tgt_we in the same IDLE cycle → write dropped; tgt_we during HASH → target unchanged.
